// File: rtl/jpeg_mcu_scheduler_if.sv
// Block-stream bundle: FWFT matrix-buffer read ports in, one tagged block stream out.
interface jpeg_mcu_scheduler_if #(
  parameter int NUM_CHANNEL = 3,
  parameter int WORD_W      = 16
);
  logic [NUM_CHANNEL-1:0]        i_nempty;
  logic [NUM_CHANNEL*WORD_W-1:0] i_md;
  logic [NUM_CHANNEL-1:0]        o_re;
  logic                          o_de;
  logic                          i_ready;
  logic [WORD_W-1:0]             o_data;
  logic [1:0]                    o_ch;
  logic                          o_blk_last;
  logic                          o_mcu_last;

  modport master (
    input  i_nempty, i_md, i_ready,
    output o_re, o_de, o_data, o_ch, o_blk_last, o_mcu_last
  );

  modport slave (
    output i_nempty, i_md, i_ready,
    input  o_re, o_de, o_data, o_ch, o_blk_last, o_mcu_last
  );
endinterface

// File: rtl/jpeg_mcu_scheduler.sv
// Merges per-channel matrix buffers into one tagged block stream, ordered per MCU
// by the run-time sampling mode, with scan/MCU/block completion flags.
module jpeg_mcu_scheduler #(
  parameter int NUM_CHANNEL = 3,
  parameter int DATA_W      = 16,
  parameter int PX_OUT      = 1,
  parameter int PY_OUT      = 1,
  parameter int MCU_WIDTH   = 8,
  parameter int MCU_HEIGHT  = 8,
  parameter int MCU_CNT_W   = 16
) (
  input  logic                 i_sysclk,
  input  logic                 i_arstn,
  input  logic                 i_start,
  input  logic [1:0]           i_mode,
  input  logic [MCU_CNT_W-1:0] i_num_mcu,
  jpeg_mcu_scheduler_if.master bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_state
);

  localparam int WORD_W    = PY_OUT * PX_OUT * DATA_W;
  localparam int BLK_WORDS = MCU_WIDTH * MCU_HEIGHT / (PX_OUT * PY_OUT);
  localparam int WC_W      = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
  localparam logic [1:0] MAX_CH = 2'(NUM_CHANNEL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [1:0]           mode_q;
  logic [MCU_CNT_W-1:0] num_mcu_q;
  logic [MCU_CNT_W-1:0] mcu_cnt;
  logic [WC_W-1:0]      word_cnt;
  logic [1:0]           blk_cnt;
  logic [1:0]           ch_idx;

  logic [1:0]        yb_last;
  logic [1:0]        last_ch;
  logic              word_last;
  logic              blk_in_ch_last;
  logic              ch_last;
  logic              mcu_end;
  logic              scan_end;
  logic              src_ne;
  logic [WORD_W-1:0] src_md;
  logic              pop;

  always_comb begin
    yb_last = 2'd0;
    case (mode_q)
      2'd1:    yb_last = 2'd1;
      2'd2:    yb_last = 2'd3;
      default: yb_last = 2'd0;
    endcase
  end

  assign last_ch        = (mode_q == 2'd3 || NUM_CHANNEL == 1) ? 2'd0 : MAX_CH;
  assign word_last      = (word_cnt == WC_W'(BLK_WORDS - 1));
  // Only luma carries more than one block per MCU.
  assign blk_in_ch_last = (ch_idx != 2'd0) || (blk_cnt == yb_last);
  assign ch_last        = (ch_idx == last_ch);
  assign mcu_end        = word_last && blk_in_ch_last && ch_last;
  assign scan_end       = mcu_end && (mcu_cnt == num_mcu_q - MCU_CNT_W'(1));

  always_comb begin
    src_ne = 1'b0;
    src_md = '0;
    for (int c = 0; c < NUM_CHANNEL; c++) begin
      if (ch_idx == 2'(c)) begin
        src_ne = bus.i_nempty[c];
        src_md = bus.i_md[c*WORD_W +: WORD_W];
      end
    end
  end

  // Handshake: a word transfers downstream on any cycle with o_de && i_ready;
  // o_de/o_data/flags are held while o_de && !i_ready, and a source word is
  // popped (o_re) only when the output register is empty or being drained.
  assign pop = (state == XFER) && !i_start && src_ne && (!bus.o_de || bus.i_ready);

  always_comb begin
    bus.o_re = '0;
    for (int c = 0; c < NUM_CHANNEL; c++) begin
      if (pop && ch_idx == 2'(c)) bus.o_re[c] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (i_start) begin
      state_nxt = (i_num_mcu == '0) ? DONE : XFER;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        XFER:    if (pop && scan_end) state_nxt = DRAIN;
        DRAIN:   if (!bus.o_de || bus.i_ready) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sysclk or negedge i_arstn) begin
    if (!i_arstn) begin
      state     <= IDLE;
      mode_q    <= 2'd0;
      num_mcu_q <= '0;
    end else begin
      state <= state_nxt;
      if (i_start) begin
        mode_q    <= i_mode;
        num_mcu_q <= i_num_mcu;
      end
    end
  end

  always_ff @(posedge i_sysclk or negedge i_arstn) begin
    if (!i_arstn) begin
      word_cnt <= '0;
      blk_cnt  <= 2'd0;
      ch_idx   <= 2'd0;
      mcu_cnt  <= '0;
    end else if (i_start) begin
      word_cnt <= '0;
      blk_cnt  <= 2'd0;
      ch_idx   <= 2'd0;
      mcu_cnt  <= '0;
    end else if (pop) begin
      if (!word_last) begin
        word_cnt <= word_cnt + WC_W'(1);
      end else begin
        word_cnt <= '0;
        if (!blk_in_ch_last) begin
          blk_cnt <= blk_cnt + 2'd1;
        end else begin
          blk_cnt <= 2'd0;
          if (ch_last) begin
            ch_idx  <= 2'd0;
            mcu_cnt <= scan_end ? '0 : mcu_cnt + MCU_CNT_W'(1);
          end else begin
            ch_idx <= ch_idx + 2'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_sysclk or negedge i_arstn) begin
    if (!i_arstn) begin
      bus.o_de       <= 1'b0;
      bus.o_data     <= '0;
      bus.o_ch       <= 2'd0;
      bus.o_blk_last <= 1'b0;
      bus.o_mcu_last <= 1'b0;
    end else if (i_start) begin
      bus.o_de <= 1'b0;
    end else if (pop) begin
      bus.o_de       <= 1'b1;
      bus.o_data     <= src_md;
      bus.o_ch       <= ch_idx;
      bus.o_blk_last <= word_last;
      bus.o_mcu_last <= mcu_end;
    end else if (bus.i_ready) begin
      bus.o_de <= 1'b0;
    end
  end

  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);
  assign o_state = state;

endmodule

// File: tb/tb_jpeg_mcu_scheduler.sv
// Bench for jpeg_mcu_scheduler: FWFT source model, expected-word queue, scenario tasks.
module tb_jpeg_mcu_scheduler;

  localparam int NCH = 3;
  localparam int W   = 16;
  localparam int EW  = W + 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] num_mcu;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  jpeg_mcu_scheduler_if #(.NUM_CHANNEL(NCH), .WORD_W(W)) bus ();

  jpeg_mcu_scheduler dut (
    .i_sysclk  (clk),
    .i_arstn   (rst_n),
    .i_start   (start),
    .i_mode    (mode),
    .i_num_mcu (num_mcu),
    .bus       (bus),
    .o_busy    (busy),
    .o_done    (done),
    .o_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- source model ----------------
  int src_cnt [NCH];

  function automatic logic [W-1:0] pat(input int c, input int k);
    return {2'(c), 14'(k)};
  endfunction

  assign bus.i_md = {pat(2, src_cnt[2]), pat(1, src_cnt[1]), pat(0, src_cnt[0])};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) src_cnt[c] <= 0;
    end else if (start) begin
      for (int c = 0; c < NCH; c++) src_cnt[c] <= 0;
    end else begin
      for (int c = 0; c < NCH; c++) if (bus.o_re[c]) src_cnt[c] <= src_cnt[c] + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks;
  int failures;
  bit mon_en;
  bit hold_prev;
  logic [EW-1:0] hold_word;
  int acc_cnt;
  int last_acc;
  int re12_cnt;
  bit done_seen;
  int done_cyc;

  wire [EW-1:0] got_word = {bus.o_mcu_last, bus.o_blk_last, bus.o_ch, bus.o_data};

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (hold_prev) begin
        checks++;
        if ({bus.o_de, got_word} !== {1'b1, hold_word}) begin
          failures++;
          $display("FAIL hold_stable got=%h exp=%h", {bus.o_de, got_word}, {1'b1, hold_word});
        end
      end
      if (bus.o_de && !bus.i_ready) begin
        checks++;
        if (bus.o_re !== '0) begin
          failures++;
          $display("FAIL pop_during_hold got=%b exp=000", bus.o_re);
        end
      end
      checks++;
      if ((bus.o_re & ~bus.i_nempty) !== '0) begin
        failures++;
        $display("FAIL re_without_nempty re=%b nempty=%b", bus.o_re, bus.i_nempty);
      end
      if (bus.o_re[1] || bus.o_re[2]) re12_cnt++;
      if (bus.o_de && bus.i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word got=%h exp=none", got_word);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          if (got_word !== e) begin
            failures++;
            $display("FAIL stream_word idx=%0d got=%h exp=%h", acc_cnt, got_word, e);
          end
        end
        acc_cnt++;
        last_acc = cyc;
      end
      hold_prev = bus.o_de && !bus.i_ready;
      hold_word = got_word;
    end else begin
      hold_prev = 1'b0;
    end
    if (rst_n && done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_scan(input int md, input int n);
    int yb, lastc, nb;
    int cnt [NCH];
    logic [EW-1:0] e;
    yb    = (md == 1) ? 2 : (md == 2) ? 4 : 1;
    lastc = (md == 3) ? 0 : NCH - 1;
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
    for (int m = 0; m < n; m++)
      for (int c = 0; c <= lastc; c++) begin
        nb = (c == 0) ? yb : 1;
        for (int b = 0; b < nb; b++)
          for (int w = 0; w < 64; w++) begin
            e = {(w == 63 && b == nb - 1 && c == lastc), (w == 63), 2'(c), pat(c, cnt[c])};
            cnt[c]++;
            exp_q.push_back(e);
          end
      end
  endtask

  task automatic pulse_start(input logic [1:0] md, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; mode = md; num_mcu = n;
    done_seen = 1'b0; acc_cnt = 0; re12_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 2'($urandom_range(0, 3));
    num_mcu = 16'($urandom_range(0, 65535));
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_seen) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_acc(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (acc_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    mon_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      num_mcu = 16'($urandom_range(0, 9));
      bus.i_nempty = 3'($urandom_range(0, 7));
      bus.i_ready = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      checks++;
      if ({bus.o_de, bus.o_data, bus.o_ch, bus.o_blk_last, bus.o_mcu_last, bus.o_re, busy, done} !== '0) begin
        failures++;
        $display("FAIL reset_outputs de=%b data=%h ch=%0d re=%b busy=%b done=%b exp=all_zero",
                 bus.o_de, bus.o_data, bus.o_ch, bus.o_re, busy, done);
      end
    end
    @(posedge clk); #1;
    start = 1'b0; bus.i_nempty = 3'b111; bus.i_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({busy, bus.o_de, dbg_state} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=0000", {busy, bus.o_de, dbg_state});
    end
    mon_en = 1'b1;
  endtask

  task automatic test_full_420();
    bit ok;
    push_scan(2, 1);
    pulse_start(2'd2, 16'd1);
    wait_done(2000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full420_done_timeout got=0 exp=1"); end
    checks++;
    if (acc_cnt != 384) begin failures++; $display("FAIL full420_words got=%0d exp=384", acc_cnt); end
    checks++;
    if (done_cyc != last_acc + 1) begin
      failures++; $display("FAIL full420_done_latency got=%0d exp=%0d", done_cyc - last_acc, 1);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL full420_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_gray();
    bit ok;
    push_scan(3, 2);
    pulse_start(2'd3, 16'd2);
    wait_done(2000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL gray_done_timeout got=0 exp=1"); end
    checks++;
    if (acc_cnt != 128) begin failures++; $display("FAIL gray_words got=%0d exp=128", acc_cnt); end
    checks++;
    if (re12_cnt != 0) begin failures++; $display("FAIL gray_chroma_re got=%0d exp=0", re12_cnt); end
  endtask

  task automatic test_backpressure_444();
    bit ok;
    push_scan(0, 1);
    pulse_start(2'd0, 16'd1);
    wait_acc(10, 500, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_reach_word10 got=0 exp=1"); end
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.i_ready = 1'b1;
    wait_done(2000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_done_timeout got=0 exp=1"); end
    checks++;
    if (acc_cnt != 192) begin failures++; $display("FAIL bp_words got=%0d exp=192", acc_cnt); end
  endtask

  task automatic test_starve_422();
    bit ok;
    bus.i_nempty = 3'b101;
    push_scan(1, 1);
    pulse_start(2'd1, 16'd1);
    wait_acc(128, 1000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL starve_reach_luma_end got=0 exp=1"); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({bus.o_de, bus.o_re} !== 4'b0000) begin
        failures++;
        $display("FAIL starve_stall cyc=%0d got_de=%b got_re=%b exp=0/000", i, bus.o_de, bus.o_re);
      end
    end
    @(posedge clk); #1;
    bus.i_nempty = 3'b111;
    wait_done(2000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL starve_done_timeout got=0 exp=1"); end
    checks++;
    if (acc_cnt != 256) begin failures++; $display("FAIL starve_words got=%0d exp=256", acc_cnt); end
  endtask

  task automatic test_abort();
    bit ok;
    push_scan(2, 1);
    pulse_start(2'd2, 16'd1);
    wait_acc(100, 1000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL abort_reach_word100 got=0 exp=1"); end
    @(posedge clk); #1;
    mon_en = 1'b0;
    start = 1'b1; mode = 2'd0; num_mcu = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({bus.o_de, busy} !== 2'b01) begin
      failures++; $display("FAIL abort_de_clear got=%b exp=01", {bus.o_de, busy});
    end
    exp_q.delete();
    acc_cnt = 0; done_seen = 1'b0;
    push_scan(0, 1);
    mon_en = 1'b1;
    wait_done(2000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL abort_done_timeout got=0 exp=1"); end
    checks++;
    if (acc_cnt != 192) begin failures++; $display("FAIL abort_words got=%0d exp=192", acc_cnt); end
  endtask

  task automatic test_zero_mcu();
    pulse_start(2'd1, 16'd0);
    checks++;
    if ({done, busy, bus.o_de} !== 3'b110) begin
      failures++; $display("FAIL zero_done_pulse got=%b exp=110", {done, busy, bus.o_de});
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy, bus.o_de} !== 3'b000) begin
      failures++; $display("FAIL zero_back_idle got=%b exp=000", {done, busy, bus.o_de});
    end
    checks++;
    if (acc_cnt != 0) begin failures++; $display("FAIL zero_words got=%0d exp=0", acc_cnt); end
  endtask

  task automatic test_random_backpressure();
    bit ok;
    push_scan(2, 2);
    pulse_start(2'd2, 16'd2);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (done_seen) begin ok = 1'b1; break; end
      bus.i_ready  = ($urandom_range(0, 3) != 0);
      bus.i_nempty = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
    end
    bus.i_ready = 1'b1;
    bus.i_nempty = 3'b111;
    checks++;
    if (!ok) begin failures++; $display("FAIL random_done_timeout got=0 exp=1"); end
    checks++;
    if (acc_cnt != 768) begin failures++; $display("FAIL random_words got=%0d exp=768", acc_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    cyc = 0; checks = 0; failures = 0;
    mon_en = 1'b0; hold_prev = 1'b0; done_seen = 1'b0;
    acc_cnt = 0; last_acc = 0; re12_cnt = 0; done_cyc = 0;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; num_mcu = 16'd0;
    bus.i_nempty = 3'b000; bus.i_ready = 1'b0;

    test_reset();
    test_full_420();
    test_gray();
    test_backpressure_444();
    test_starve_422();
    test_abort();
    test_zero_mcu();
    test_random_backpressure();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
